// File: rtl/spi_reg_ctrl.sv
// Framed register-access controller behind an SPI slave byte engine.
// One command byte (R/W + 7-bit address) per CS-low frame, then auto-incrementing data bytes.
module spi_reg_ctrl #(
    parameter logic [7:0] STATUS_BYTE = 8'hA5,
    parameter logic [7:0] DUMMY_BYTE  = 8'h00
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cs,
    input  logic       byte_ack,
    input  logic [7:0] byte_rx,
    output logic [7:0] byte_tx,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       err_ovr,
    input  logic       err_clr
);

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD
    } state_t;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_WAIT,
        PF_LOAD
    } pf_state_t;

    // cs idles high, so the synchronizer resets to the deselected level
    logic cs_sync_reg [SYNC_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_cs_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                    if (!sys_rst_n) cs_sync_reg[gi] <= 1'b1;
                    else            cs_sync_reg[gi] <= cs;
                end
            end else begin : g_next
                always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                    if (!sys_rst_n) cs_sync_reg[gi] <= 1'b1;
                    else            cs_sync_reg[gi] <= cs_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    logic cs_hi;
    assign cs_hi = cs_sync_reg[SYNC_STAGES-1];

    state_t    state_reg,    state_next;
    pf_state_t pf_state_reg, pf_state_next;
    logic [6:0] addr_reg,      addr_next;
    logic [7:0] pf_reg,        pf_next;
    logic [7:0] byte_tx_reg,   byte_tx_next;
    logic [6:0] reg_addr_reg,  reg_addr_next;
    logic [7:0] reg_wdata_reg, reg_wdata_next;
    logic       reg_wr_reg,    reg_wr_next;
    logic       reg_rd_reg,    reg_rd_next;
    logic       err_ovr_reg,   err_ovr_next;
    logic [6:0] addr_inc;

    assign addr_inc = addr_reg + 7'd1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= ST_IDLE;
            pf_state_reg  <= PF_IDLE;
            addr_reg      <= 7'd0;
            pf_reg        <= 8'd0;
            byte_tx_reg   <= STATUS_BYTE;
            reg_addr_reg  <= 7'd0;
            reg_wdata_reg <= 8'd0;
            reg_wr_reg    <= 1'b0;
            reg_rd_reg    <= 1'b0;
            err_ovr_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pf_state_reg  <= pf_state_next;
            addr_reg      <= addr_next;
            pf_reg        <= pf_next;
            byte_tx_reg   <= byte_tx_next;
            reg_addr_reg  <= reg_addr_next;
            reg_wdata_reg <= reg_wdata_next;
            reg_wr_reg    <= reg_wr_next;
            reg_rd_reg    <= reg_rd_next;
            err_ovr_reg   <= err_ovr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pf_state_next  = pf_state_reg;
        addr_next      = addr_reg;
        pf_next        = pf_reg;
        byte_tx_next   = byte_tx_reg;
        reg_addr_next  = addr_reg;
        reg_wdata_next = reg_wdata_reg;
        reg_wr_next    = 1'b0;
        reg_rd_next    = 1'b0;
        err_ovr_next   = err_clr ? 1'b0 : err_ovr_reg;

        // Prefetch pipeline: read data returns one cycle after the strobe
        case (pf_state_reg)
            PF_WAIT: pf_state_next = PF_LOAD;
            PF_LOAD: begin
                pf_next       = reg_rdata;
                pf_state_next = PF_IDLE;
            end
            default: pf_state_next = PF_IDLE;
        endcase

        if (cs_hi) begin
            state_next    = ST_IDLE;
            byte_tx_next  = STATUS_BYTE;
            pf_state_next = PF_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_CMD;
                ST_CMD: begin
                    if (byte_ack) begin
                        addr_next     = byte_rx[6:0];
                        reg_addr_next = byte_rx[6:0];
                        if (byte_rx[7]) begin
                            byte_tx_next  = DUMMY_BYTE;
                            reg_rd_next   = 1'b1;
                            pf_state_next = PF_WAIT;
                            state_next    = ST_RD;
                        end else begin
                            state_next = ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (byte_ack) begin
                        reg_wr_next    = 1'b1;
                        reg_wdata_next = byte_rx;
                        reg_addr_next  = addr_reg;
                        addr_next      = addr_inc;
                    end
                end
                ST_RD: begin
                    if (byte_ack) begin
                        // pf_reg is the pre-capture value, so an overrun ships the stale byte
                        byte_tx_next  = pf_reg;
                        addr_next     = addr_inc;
                        reg_addr_next = addr_inc;
                        reg_rd_next   = 1'b1;
                        pf_state_next = PF_WAIT;
                        if (pf_state_reg != PF_IDLE) err_ovr_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign byte_tx   = byte_tx_reg;
    assign reg_addr  = reg_addr_reg;
    assign reg_wdata = reg_wdata_reg;
    assign reg_wr    = reg_wr_reg;
    assign reg_rd    = reg_rd_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign err_ovr   = err_ovr_reg;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_spi_reg_ctrl;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cs        = 1'b1;
    logic       byte_ack  = 1'b0;
    logic [7:0] byte_rx   = 8'h00;
    logic       err_clr   = 1'b0;
    logic [7:0] byte_tx;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       err_ovr;

    spi_reg_ctrl dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cs        (cs),
        .byte_ack  (byte_ack),
        .byte_rx   (byte_rx),
        .byte_tx   (byte_tx),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .err_ovr   (err_ovr),
        .err_clr   (err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    // Register file behind the bus
    logic [7:0] mem [128];

    function automatic logic [7:0] preload(input int i);
        if (i == 126) return 8'hC1;
        if (i == 127) return 8'hC2;
        return ~8'(i);
    endfunction

    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 128; i++) mem[i] <= preload(i);
            reg_rdata <= 8'h00;
        end else begin
            if (reg_wr) mem[reg_addr] <= reg_wdata;
            if (reg_rd) reg_rdata <= mem[reg_addr];
        end
    end

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int         sel;
        logic [7:0] exp;
        string      name;
    } st_t;

    wr_t        wr_q[$];
    logic [6:0] rd_q[$];
    logic [7:0] miso_q[$];
    st_t        st_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    endtask

    // Monitor: compares every strobe, every completed byte and every queued status probe
    always @(negedge sys_clk) begin
        wr_t w;
        st_t s;
        logic [7:0] act;
        if (sys_rst_n) begin
            if (reg_wr || reg_rd) check("strobe_excl", {7'd0, reg_wr & reg_rd}, 8'h00);
            if (reg_wr) begin
                if (wr_q.size() == 0) check("wr_unexpected", 8'h01, 8'h00);
                else begin
                    w = wr_q.pop_front();
                    check("wr_addr", {1'b0, reg_addr}, {1'b0, w.addr});
                    check("wr_data", reg_wdata, w.data);
                    $display("write addr=%02h data=%02h", reg_addr, reg_wdata);
                end
            end
            if (reg_rd) begin
                if (rd_q.size() == 0) check("rd_unexpected", 8'h01, 8'h00);
                else begin
                    check("rd_addr", {1'b0, reg_addr}, {1'b0, rd_q.pop_front()});
                    $display("read strobe addr=%02h", reg_addr);
                end
            end
            if (byte_ack) begin
                if (miso_q.size() == 0) check("miso_unexpected", 8'h01, 8'h00);
                else begin
                    check("miso", byte_tx, miso_q.pop_front());
                    $display("byte rx=%02h miso=%02h", byte_rx, byte_tx);
                end
            end
        end
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            act = 8'h00;
            case (s.sel)
                0: act = {7'd0, busy};
                1: act = byte_tx;
                2: act = {7'd0, err_ovr};
                3: act = {1'b0, reg_addr};
                4: act = reg_wdata;
                5: act = {7'd0, reg_wr};
                6: act = {7'd0, reg_rd};
                7: act = 8'(wr_q.size() + rd_q.size() + miso_q.size());
                default: act = 8'h00;
            endcase
            if (s.sel == 8) begin
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end else begin
                check(s.name, act, s.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic expect_st(input int sel, input logic [7:0] e, input string nm);
        st_t s;
        s.sel  = sel;
        s.exp  = e;
        s.name = nm;
        st_q.push_back(s);
    endtask

    task automatic exp_wr(input logic [6:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic exp_rd(input logic [6:0] a);
        rd_q.push_back(a);
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] miso, input int gap);
        miso_q.push_back(miso);
        byte_rx  = b;
        byte_ack = 1'b1;
        tick(1);
        byte_ack = 1'b0;
        tick(gap);
    endtask

    task automatic frame_start();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        cs = 1'b1;
        tick(4);
    endtask

    initial begin
        // Reset values while held in reset
        #1;
        expect_st(0, 8'h00, "rst_busy");
        expect_st(1, 8'hA5, "rst_byte_tx");
        expect_st(2, 8'h00, "rst_err_ovr");
        expect_st(3, 8'h00, "rst_reg_addr");
        expect_st(4, 8'h00, "rst_reg_wdata");
        expect_st(5, 8'h00, "rst_reg_wr");
        expect_st(6, 8'h00, "rst_reg_rd");
        tick(3);
        sys_rst_n = 1'b1;
        tick(2);

        // Write burst 0x10: 11 22 33
        frame_start();
        send(8'h10, 8'hA5, 6);
        exp_wr(7'h10, 8'h11); send(8'h11, 8'hA5, 6);
        exp_wr(7'h11, 8'h22); send(8'h22, 8'hA5, 6);
        exp_wr(7'h12, 8'h33); send(8'h33, 8'hA5, 1);
        expect_st(3, 8'h13, "wr_addr_inc");
        expect_st(0, 8'h01, "busy_in_frame");
        frame_end();

        // Read burst at 0x7E with wrap to 0x00
        frame_start();
        exp_rd(7'h7E); send(8'hFE, 8'hA5, 6);
        exp_rd(7'h7F); send(8'h00, 8'h00, 6);
        exp_rd(7'h00); send(8'h00, 8'hC1, 6);
        exp_rd(7'h01); send(8'h00, 8'hC2, 6);
        frame_end();
        expect_st(1, 8'hA5, "rd_end_byte_tx");
        expect_st(0, 8'h00, "rd_end_busy");

        // Abort after command byte, check cs sync latency
        frame_start();
        send(8'h05, 8'hA5, 4);
        cs = 1'b1;
        tick(2);
        expect_st(0, 8'h01, "busy_sync_delay");
        tick(1);
        expect_st(0, 8'h00, "busy_drop");
        expect_st(1, 8'hA5, "abort_byte_tx");
        tick(2);
        frame_start();
        exp_wr(7'h20, 8'h5A);
        send(8'h20, 8'hA5, 6);
        send(8'h5A, 8'hA5, 6);
        frame_end();

        // Overrun, sticky flag, clear, and clear colliding with overrun
        frame_start();
        exp_rd(7'h40); send(8'hC0, 8'hA5, 6);
        exp_rd(7'h41); send(8'h00, 8'h00, 1);
        exp_rd(7'h42); send(8'h00, 8'hBF, 6);
        expect_st(2, 8'h01, "err_ovr_set");
        exp_rd(7'h43); send(8'h00, 8'hBF, 6);
        expect_st(2, 8'h01, "err_ovr_sticky");
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        expect_st(2, 8'h00, "err_ovr_clr");
        exp_rd(7'h44); send(8'h00, 8'hBD, 1);
        exp_rd(7'h45);
        miso_q.push_back(8'hBC);
        byte_rx  = 8'h00;
        byte_ack = 1'b1;
        err_clr  = 1'b1;
        tick(1);
        byte_ack = 1'b0;
        err_clr  = 1'b0;
        expect_st(2, 8'h01, "err_ovr_collide");
        tick(6);
        frame_end();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;

        // Back-to-back write then read of the same address
        frame_start();
        exp_wr(7'h25, 8'h9C);
        send(8'h25, 8'hA5, 6);
        send(8'h9C, 8'hA5, 6);
        frame_end();
        expect_st(0, 8'h00, "busy_gap");
        frame_start();
        exp_rd(7'h25); send(8'hA5, 8'hA5, 6);
        exp_rd(7'h26); send(8'h00, 8'h00, 6);
        exp_rd(7'h27); send(8'h00, 8'h9C, 6);
        frame_end();

        // Asynchronous reset mid-frame
        frame_start();
        send(8'h30, 8'hA5, 6);
        exp_wr(7'h30, 8'h77); send(8'h77, 8'hA5, 3);
        sys_rst_n = 1'b0;
        expect_st(0, 8'h00, "arst_busy");
        expect_st(1, 8'hA5, "arst_byte_tx");
        expect_st(3, 8'h00, "arst_reg_addr");
        expect_st(4, 8'h00, "arst_reg_wdata");
        expect_st(5, 8'h00, "arst_reg_wr");
        cs = 1'b1;
        tick(2);
        sys_rst_n = 1'b1;
        tick(4);
        expect_st(0, 8'h00, "post_rst_busy");
        expect_st(1, 8'hA5, "post_rst_byte_tx");

        expect_st(7, 8'h00, "queues_empty");
        expect_st(8, 8'h00, "finish");
        tick(4);
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-access controller that sits behind the SPI slave byte engine and turns its byte stream into a framed register protocol. Each CS-low frame has one command byte (R/W flag plus 7-bit address) followed by data bytes. The data bytes are either written to consecutive registers or read back from them, with address auto-increment. The block drives the byte engine's transmit byte and a simple single-cycle register bus into the FPGA register file.

## Interface
Parameters:
- STATUS_BYTE, 8'hA5: value shifted out on MISO during the command byte.
- DUMMY_BYTE, 8'h00: value shifted out during the turnaround byte of a read frame.

Ports:
- sys_clk  in  1  system clock; all logic runs on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- cs  in  1  SPI chip select, active low; same raw pin that the byte engine receives.
- byte_ack  in  1  one-cycle pulse from the byte engine marking a completed byte.
- byte_rx  in  8  received byte; valid in the cycle byte_ack is high.
- byte_tx  out  8  byte the engine loads for the next transfer; registered.
- reg_addr  out  7  register bus address; registered.
- reg_wdata  out  8  write data; registered.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data; valid exactly 1 cycle after reg_rd.
- busy  out  1  high while a frame is active (state not IDLE).
- err_ovr  out  1  sticky prefetch-overrun flag.
- err_clr  in  1  synchronous clear for err_ovr.

## Operation
- Reset values:
  - byte_tx = STATUS_BYTE.
  - reg_addr = 0 and reg_wdata = 0.
  - reg_wr, reg_rd, busy and err_ovr = 0.
  - State = IDLE and prefetch register pf = 0.
- cs is double-registered into the controller.
  - The synced cs gates everything else.
  - Synced cs high forces state to IDLE from any state next cycle and sets byte_tx = STATUS_BYTE.
  - A frame aborted mid-byte issues no strobe for the incomplete byte.
- States and transitions:
  - IDLE → CMD when synced cs goes low.
  - CMD, on byte_ack:
    - Latch addr = byte_rx[6:0].
    - If byte_rx[7] = 0 (write), go to WR.
    - If byte_rx[7] = 1 (read), set byte_tx = DUMMY_BYTE, issue a read of addr into pf, then go to RD.
  - WR, on each byte_ack: reg_wr pulse with reg_addr = addr and reg_wdata = byte_rx, then addr increments.
  - RD, on each byte_ack:
    - byte_tx ← pf.
    - addr increments.
    - A read of the new addr is issued, with pf ← reg_rdata.
- Address arithmetic: 7-bit, wraps 127 → 0. No carry out.
- Prefetch sequence is internal sub-state PF_IDLE / PF_WAIT / PF_LOAD: reg_rd pulse, then capture reg_rdata into pf 1 cycle later.
- Overrun: byte_ack arriving in RD while the prefetch is not back in PF_IDLE.
  - Sets err_ovr.
  - byte_tx ← stale pf.
  - The new prefetch restarts normally.
- err_clr clears err_ovr. A simultaneous overrun wins, so err_ovr stays 1.
- reg_wr and reg_rd are never high in the same cycle.

## Timing
- Write: byte_ack at cycle t.
  - reg_wr = 1 at t+1 with reg_addr = a and reg_wdata = the byte.
  - reg_addr = a+1 from t+2.
- Read, CMD ack at t:
  - byte_tx = DUMMY_BYTE at t+1.
  - reg_rd = 1 at t+1 with reg_addr = a.
  - pf valid at t+3.
- Read, RD ack at t:
  - byte_tx = pf at t+1. This satisfies the engine's requirement that byte_tx is stable within 2 cycles of byte_ack.
  - reg_rd at t+1 for the next address.
  - pf updated at t+3.
- Minimum byte spacing for overrun-free reads: 3 cycles between byte_ack pulses. Any real SCLK rate meets this.
- cs rising at t (raw pin): busy = 0 and byte_tx = STATUS_BYTE at t+3 (2 sync stages plus 1 register).
- byte_ack while synced cs is high is ignored.

## Test plan
- Reset: assert sys_rst_n low mid-frame → all outputs at their reset values immediately; after release, busy = 0 and byte_tx = 8'hA5.
- Write burst: frame 0x10, 0x11, 0x22, 0x33 → reg_wr pulses at addr 0x10/0x11/0x12 with data 0x11/0x22/0x33; byte_tx stays 0xA5 throughout.
- Read burst: register file preloaded with reg[0x7E] = 0xC1 and reg[0x7F] = 0xC2. Frame 0xFE followed by 3 bytes, then CS high → MISO bytes are 0xA5, 0x00, 0xC1, 0xC2. The third read prefetches address 0x00 (wrap check). The remaining pf value is discarded at CS high.
- Abort: cs raised after the command byte 0x05 plus 4 SCLK edges → no reg_wr; the next frame starts cleanly in CMD.
- Overrun: force byte_ack pulses 2 cycles apart in RD → err_ovr = 1 and stays 1. An err_clr pulse later → 0. err_clr in the same cycle as a new overrun → stays 1.
- Back-to-back frames: write frame, then CS high for 4 cycles, then read frame of the same address → read returns the written value; busy drops between the frames.
